// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared state and 1-bit ALU operation encodings
// Used by the bit-serial sequencer and anything modelling the ALU slice.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // mode selects arithmetic (1) or logic (0); opsel picks the function
   localparam logic       MODE_ARITH = 1'b1;
   localparam logic       MODE_LOGIC = 1'b0;
   localparam logic [2:0] OPSEL_ADD  = 3'b000;
   localparam logic [2:0] OPSEL_AND  = 3'b000;
   localparam logic [2:0] OPSEL_OR   = 3'b001;
   localparam logic [2:0] OPSEL_XOR  = 3'b010;

endpackage

// File: rtl/serial_alu_sequencer.sv
// rtl/serial_alu_sequencer.sv - bit-serial front end for the 1-bit ALU slice
// Walks a WIDTH-bit operation LSB first through the slice, feeding carry back.
module serial_alu_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       opsel,
   input  logic             mode,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             op1,
   output logic             op2,
   output logic             Cin_final,
   output logic [2:0]       alu_opsel,
   output logic             alu_mode,
   input  logic             result_final,
   input  logic             Cout_final
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [2:0]       r_opsel;
   logic             r_mode;
   logic             r_busy;
   logic             r_done;

   logic             w_accept;
   logic             w_last;

   assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_last   = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_opsel  <= 3'b000;
         r_mode   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
                  r_state  <= RUN;
                  r_a      <= a;
                  r_b      <= b;
                  r_opsel  <= opsel;
                  r_mode   <= mode;
                  r_carry  <= cin;
                  r_cnt    <= '0;
                  r_result <= '0;
                  r_cout   <= 1'b0;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
               end
            end
            RUN: begin
               // result fills from the MSB so bit 0 lands at the LSB after WIDTH shifts
               r_result <= {result_final, r_result[WIDTH-1:1]};
               r_carry  <= Cout_final;
               r_a      <= {1'b0, r_a[WIDTH-1:1]};
               r_b      <= {1'b0, r_b[WIDTH-1:1]};
               r_cnt    <= r_cnt + CW'(1);
               if (w_last) begin
                  r_state <= DONE;
                  r_cout  <= Cout_final;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign result    = r_result;
   assign cout      = r_cout;
   // slice inputs are forced quiet whenever no operation is walking
   assign op1       = r_busy & r_a[0];
   assign op2       = r_busy & r_b[0];
   assign Cin_final = r_busy & r_carry;
   assign alu_opsel = r_opsel;
   assign alu_mode  = r_mode;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// tb/tb_serial_alu_sequencer.sv - self-checking bench for serial_alu_sequencer
// Pairs the sequencer with a behavioural 1-bit ALU and checks against word-level arithmetic.
module tb_serial_alu_sequencer;
   import alu_pkg::*;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       opsel;
   logic             mode;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             op1;
   logic             op2;
   logic             Cin_final;
   logic [2:0]       alu_opsel;
   logic             alu_mode;
   logic             result_final;
   logic             Cout_final;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_alu_sequencer #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .opsel(opsel), .mode(mode), .cin(cin), .busy(busy), .done(done),
      .result(result), .cout(cout), .op1(op1), .op2(op2),
      .Cin_final(Cin_final), .alu_opsel(alu_opsel), .alu_mode(alu_mode),
      .result_final(result_final), .Cout_final(Cout_final)
   );

   // behavioural 1-bit ALU slice; logic ops report no carry
   always_comb begin
      result_final = 1'b0;
      Cout_final   = 1'b0;
      if (alu_mode == MODE_ARITH) begin
         if (alu_opsel == OPSEL_ADD) begin
            result_final = op1 ^ op2 ^ Cin_final;
            Cout_final   = (op1 & op2) | (op1 & Cin_final) | (op2 & Cin_final);
         end
      end else begin
         case (alu_opsel)
            OPSEL_AND: result_final = op1 & op2;
            OPSEL_OR:  result_final = op1 | op2;
            OPSEL_XOR: result_final = op1 ^ op2;
            default:   result_final = 1'b0;
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // word-level reference: {cout, result}
   function automatic logic [WIDTH:0] ref_op(input int kind, input logic [WIDTH-1:0] ia,
                                             input logic [WIDTH-1:0] ib, input logic ic);
      case (kind)
         0:       return {1'b0, ia} + {1'b0, ib} + {{WIDTH{1'b0}}, ic};
         1:       return {1'b0, ia & ib};
         2:       return {1'b0, ia | ib};
         default: return {1'b0, ia ^ ib};
      endcase
   endfunction

   function automatic logic [2:0] kind_opsel(input int kind);
      case (kind)
         0:       return OPSEL_ADD;
         1:       return OPSEL_AND;
         2:       return OPSEL_OR;
         default: return OPSEL_XOR;
      endcase
   endfunction

   task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input int kind, input logic ic);
      @(negedge clk);
      a     = ia;
      b     = ib;
      opsel = kind_opsel(kind);
      mode  = (kind == 0) ? MODE_ARITH : MODE_LOGIC;
      cin   = ic;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // lat counts edges since the accepting edge; done is expected at lat == WIDTH
   task automatic wait_done(input int lat0, output int lat,
                            output logic [WIDTH-1:0] s1, output logic [WIDTH-1:0] s2);
      lat = lat0;
      s1  = '0;
      s2  = '0;
      while (!done && lat < lat0 + 4 * WIDTH) begin
         if (busy && lat < WIDTH) begin
            s1[lat] = op1;
            s2[lat] = op2;
         end
         if (busy && done) check("busy_done_overlap", 1, 0);
         @(posedge clk);
         #1;
         lat++;
      end
      if (!done) check("done_timeout", 0, 1);
   endtask

   task automatic run_op(input string tag, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input int kind, input logic ic,
                         output logic [WIDTH-1:0] s1, output logic [WIDTH-1:0] s2);
      int lat;
      logic [WIDTH:0] exp;
      exp = ref_op(kind, ia, ib, ic);
      issue(ia, ib, kind, ic);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_opsel"}, alu_opsel, kind_opsel(kind));
      wait_done(0, lat, s1, s2);
      check({tag, "_latency"}, lat + 1, WIDTH + 1);
      check({tag, "_result"}, result, exp[WIDTH-1:0]);
      check({tag, "_cout"}, cout, exp[WIDTH]);
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, {busy, done}, 2'b00);
      check({tag, "_result_held"}, result, exp[WIDTH-1:0]);
   endtask

   initial begin
      logic [WIDTH-1:0] s1, s2;
      int lat;
      int saw_done;
      rst_n = 1'b0;
      start = 1'b0;
      a = '0; b = '0; opsel = 3'b000; mode = 1'b0; cin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_flags", {busy, done, cout}, 3'b000);
      check("rst_result", result, 0);
      check("rst_alu_in", {op1, op2, Cin_final}, 3'b000);
      check("rst_alu_sel", {alu_opsel, alu_mode}, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add_5a3c", 8'h5A, 8'h3C, 0, 1'b0, s1, s2);
      run_op("add_ff01", 8'hFF, 8'h01, 0, 1'b0, s1, s2);
      run_op("add_cin", 8'h00, 8'h00, 0, 1'b1, s1, s2);
      run_op("xor_a5ff", 8'hA5, 8'hFF, 3, 1'b0, s1, s2);
      check("xor_op1_seq", s1, 8'hA5);
      check("xor_op2_seq", s2, 8'hFF);
      check("xor_mode", alu_mode, MODE_LOGIC);

      // start re-pulsed in cycle 3 of RUN must be ignored
      issue(8'h5A, 8'h3C, 0, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      a = 8'hC3; b = 8'h77; opsel = OPSEL_XOR; mode = MODE_LOGIC; cin = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(3, lat, s1, s2);
      check("ign_latency", lat + 1, WIDTH + 1);
      check("ign_result", result, 8'h96);
      check("ign_cout", cout, 0);
      check("ign_sel", {alu_opsel, alu_mode}, {OPSEL_ADD, MODE_ARITH});
      @(posedge clk);
      #1;

      // reset during cycle 4 of RUN aborts with no done pulse
      issue(8'h5A, 8'h3C, 0, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      check("abort_pre_op1", op1, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_clear", {busy, cout, op1}, 3'b000);
      check("abort_result", result, 0);
      saw_done = 0;
      repeat (3) begin @(posedge clk); #1; if (done) saw_done = 1; end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (WIDTH + 2) begin @(posedge clk); #1; if (done) saw_done = 1; end
      check("abort_no_done", saw_done, 0);
      run_op("add_1020", 8'h10, 8'h20, 0, 1'b0, s1, s2);

      // start held through the done cycle launches the next op back-to-back
      issue(8'h5A, 8'h3C, 0, 1'b0);
      for (int k = 0; k < WIDTH - 2; k++) begin @(posedge clk); #1; end
      @(negedge clk);
      a = 8'h01; b = 8'h01; opsel = OPSEL_ADD; mode = MODE_ARITH; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      check("b2b_still_busy", busy, 1);
      @(posedge clk);
      #1;
      check("b2b_done", {busy, done}, 2'b01);
      check("b2b_first_result", result, 8'h96);
      @(negedge clk);
      check("b2b_first_held", result, 8'h96);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b_restart", {busy, done}, 2'b10);
      check("b2b_cleared", result, 0);
      wait_done(0, lat, s1, s2);
      check("b2b_latency", lat + 1, WIDTH + 1);
      check("b2b_result", result, 8'h02);
      @(posedge clk);
      #1;

      for (int t = 0; t < 30; t++) begin
         logic [WIDTH-1:0] ra, rb;
         int kind;
         ra   = WIDTH'($urandom);
         rb   = WIDTH'($urandom);
         kind = int'($urandom_range(0, 3));
         run_op($sformatf("rnd%0d", t), ra, rb, kind, 1'($urandom_range(0, 1)), s1, s2);
         check($sformatf("rnd%0d_op1_seq", t), s1, ra);
         check($sformatf("rnd%0d_op2_seq", t), s2, rb);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/serial_alu_sequencer.md
# serial_alu_sequencer

Bit-serial front end for the team's 1-bit ALU slice. It accepts a WIDTH-bit operation, walks it through the 1-bit ALU one bit per clock from LSB to MSB, and feeds the slice's carry-out back into its carry-in. It collects the WIDTH result bits and the final carry into registered outputs. It sits directly upstream of the 1-bit ALU: it drives the slice's inputs and consumes its outputs.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request pulse; accepted only in IDLE or DONE
- a  input  WIDTH  operand A, sampled on accepted start
- b  input  WIDTH  operand B, sampled on accepted start
- opsel  input  3  ALU operation select, sampled on accepted start
- mode  input  1  ALU mode, sampled on accepted start
- cin  input  1  carry into bit 0, sampled on accepted start
- busy  output  1  high while the operation is in progress
- done  output  1  one-cycle pulse when result/cout become valid
- result  output  WIDTH  assembled result, held until the next accepted start
- cout  output  1  carry-out of the MSB slice, held with result
- op1  output  1  to ALU: current bit of A
- op2  output  1  to ALU: current bit of B
- Cin_final  output  1  to ALU: current carry-in
- alu_opsel  output  3  to ALU: latched opsel
- alu_mode  output  1  to ALU: latched mode
- result_final  input  1  from ALU: result bit (combinational from op1/op2/Cin_final)
- Cout_final  input  1  from ALU: carry-out bit

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on start.
  - Latch a/b into shift registers, opsel/mode, and carry register ← cin.
  - Clear the bit counter.
  - Clear result and cout.
- RUN, each cycle:
  - op1/op2 = LSB of the A/B shift registers; Cin_final = carry register.
  - At the edge: result shifts right with result_final entering at the MSB; carry ← Cout_final; A/B shift right; counter increments.
  - After the capture with counter = WIDTH-1, go to DONE. cout ← Cout_final on that edge.
- DONE, one cycle: done=1. If start is high, go to RUN with a new latch (same as from IDLE); otherwise go to IDLE.
- start in RUN is ignored: no latch, no effect.
- Outside RUN, op1, op2 and Cin_final are driven to 0. alu_opsel and alu_mode always show the latched values.
- The carry chain is applied for every opsel/mode. For logic ops, cout reports whatever the slice produced.
- Counter width is $clog2(WIDTH). No wrap is reachable, because the exit happens at WIDTH-1.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, busy=0, done=0, result=0, cout=0, op1=op2=Cin_final=0, alu_opsel=0, alu_mode=0, all internal registers 0.
- Reset asserted mid-RUN aborts the operation immediately. No done pulse is produced.
- start sampled at edge E0: busy=1 from after E0 through the RUN cycle ending at edge E(WIDTH).
- Bit i is presented to the ALU in cycle i+1 after E0.
- done=1 in the cycle after E(WIDTH). result/cout are valid from E(WIDTH) onward.
- Latency from start to done is WIDTH+1 cycles. Back-to-back throughput is one op per WIDTH+1 cycles, using start during DONE.
- busy and done are never high together.

## Structure
- Package alu_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - opsel/mode encodings shared with the ALU and bench: mode=1 opsel=3'b000 ADD; mode=0 opsel 3'b000 AND, 3'b001 OR, 3'b010 XOR.
- Single module, no sub-modules. The 1-bit ALU is instantiated beside this block at the next level up, not inside it.
- The bench pairs this block with the real 1-bit ALU, or with a behavioural model of the same encodings.

## Test plan
- ADD, a=8'h5A, b=8'h3C, cin=0 → result=8'h96, cout=0, done exactly 9 cycles after start.
- ADD, a=8'hFF, b=8'h01, cin=0 → result=8'h00, cout=1. Also ADD 8'h00+8'h00 with cin=1 → 8'h01, cout=0.
- XOR (mode 0, opsel 3'b010), a=8'hA5, b=8'hFF → result=8'h5A. op1/op2 follow bit order LSB→MSB: a → 1,0,1,0,0,1,0,1.
- start re-pulsed at cycle 3 of RUN with different operands → ignored; the original ADD 5A+3C still yields 8'h96 at cycle 9.
- rst_n low during cycle 4 of RUN → busy, result, cout and op1 go to 0 at once, no done pulse. A following ADD 8'h10+8'h20 → 8'h30.
- start held high through the done cycle with new operands 8'h01+8'h01 → second op latched, busy rises the next cycle, result=8'h02 nine cycles later. The first result stays held until that second start.
